// File: rtl/cesa_seq_adder.sv
// Carry-estimating speculative adder built from 4-bit segments, with a
// registered misprediction check, optional one-cycle correction and error counter.
module cesa_seq_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             err_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned NSEG = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, SPEC, FIX, HOLD} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cin_q, mode_q, cout_q, err_q, tcout_q;
    logic [NSEG-1:0]  tc_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [NSEG-1:0]  est, tco, tcin;
    logic [WIDTH:0]   rc;
    logic [WIDTH-1:0] spec_sum, fix_sum;
    logic [4:0]       seg_s, seg_f;
    logic             mis, seg_c;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic est_fn(input logic [3:0] a, input logic [3:0] b);
        logic sel, pre, post;
        sel  = (a[3] ^ b[3]) & (a[2] ^ b[2]);
        pre  = maj(a[1], b[1], a[0] & b[0]);
        post = maj(a[3], b[3], a[2] & b[2]);
        return sel ? pre : post;
    endfunction

    // Returns {carry_out, sum[3:0]} of a 4-bit ripple from carry c.
    function automatic logic [4:0] seg_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] r;
        logic       cc;
        r  = '0;
        cc = c;
        for (int unsigned j = 0; j < 4; j++) begin
            r[j] = a[j] ^ b[j] ^ cc;
            cc   = maj(a[j], b[j], cc);
        end
        r[4] = cc;
        return r;
    endfunction

    // Reference ripple over the full width; only its per-segment carries are kept for FIX.
    always_comb begin
        rc    = '0;
        rc[0] = cin_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rc[i+1] = maj(a_q[i], b_q[i], rc[i]);
        end
    end

    always_comb begin
        est      = '0;
        tco      = '0;
        tcin     = '0;
        spec_sum = '0;
        fix_sum  = '0;
        seg_s    = '0;
        seg_f    = '0;
        seg_c    = 1'b0;
        for (int unsigned k = 0; k < NSEG; k++) begin
            est[k]  = est_fn(a_q[4*k +: 4], b_q[4*k +: 4]);
            tco[k]  = rc[4*k+4];
            tcin[k] = rc[4*k];
            seg_c   = (k == 0) ? cin_q : est[k-1];
            seg_s   = seg_add(a_q[4*k +: 4], b_q[4*k +: 4], seg_c);
            spec_sum[4*k +: 4] = seg_s[3:0];
            seg_f   = seg_add(a_q[4*k +: 4], b_q[4*k +: 4], tc_q[k]);
            fix_sum[4*k +: 4]  = seg_f[3:0];
        end
    end

    assign mis = |(est ^ tco);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = SPEC;
            SPEC:    state_d = (mode_q && mis) ? FIX : HOLD;
            FIX:     state_d = HOLD;
            HOLD:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            mode_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            tc_q    <= '0;
            tcout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q    <= a_i;
                        b_q    <= b_i;
                        cin_q  <= cin_i;
                        mode_q <= mode_i;
                    end
                end
                SPEC: begin
                    tc_q    <= tcin;
                    tcout_q <= rc[WIDTH];
                    if (!mode_q || !mis) begin
                        sum_q  <= spec_sum;
                        cout_q <= est[NSEG-1];
                        err_q  <= mis;
                    end
                end
                FIX: begin
                    sum_q  <= fix_sum;
                    cout_q <= tcout_q;
                    err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            err_cnt_q <= '0;
        end else if (state_q == HOLD && out_ready_i && err_q && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == HOLD);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cesa_seq_adder.sv
// Directed bench for cesa_seq_adder at WIDTH=8; a 4-bit counter keeps the
// saturation sequence short.
module tb_cesa_seq_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             cin_i = 1'b0;
    logic             mode_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             err_o;
    logic             clr_cnt_i = 1'b0;
    logic [CNT_W-1:0] err_cnt_o;

    int checks = 0;
    int errors = 0;
    int lat;
    int exp_cnt;

    cesa_seq_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .mode_i(mode_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sum_o(sum_o), .cout_o(cout_o), .err_o(err_o),
        .clr_cnt_i(clr_cnt_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set for a single cycle; returns at the first negedge
    // after the accepting edge, with junk left on the operand inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic m);
        @(negedge clk_i);
        a_i = a; b_i = b; cin_i = c; mode_i = m; in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0; a_i = ~a; b_i = 8'h5A; cin_i = ~c; mode_i = ~m;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid_o && l < 10) begin
            @(negedge clk_i);
            l++;
        end
    endtask

    task automatic handshake(input logic clr);
        out_ready_i = 1'b1; clr_cnt_i = clr;
        @(negedge clk_i);
        out_ready_i = 1'b0; clr_cnt_i = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_sum", sum_o, 0);
        chk("rst_cout", cout_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cnt", err_cnt_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 0x12+0x34 exact: no misprediction
        start_op(8'h12, 8'h34, 1'b0, 1'b1);
        chk("op1_busy_ready", in_ready_o, 0);
        chk("op1_spec_valid", out_valid_o, 0);
        wait_valid(lat);
        chk("op1_latency", lat, 2);
        chk("op1_sum", sum_o, 8'h46);
        chk("op1_cout", cout_o, 0);
        chk("op1_err", err_o, 0);
        handshake(1'b0);
        chk("op1_ready_after", in_ready_o, 1);
        chk("op1_cnt", err_cnt_o, 0);

        // 0x05+0xFA+1 approximate: speculative result with error flag
        start_op(8'h05, 8'hFA, 1'b1, 1'b0);
        wait_valid(lat);
        chk("op2_latency", lat, 2);
        chk("op2_sum", sum_o, 8'hF0);
        chk("op2_cout", cout_o, 0);
        chk("op2_err", err_o, 1);
        handshake(1'b0);
        chk("op2_cnt", err_cnt_o, 1);

        // Same operands exact: corrected through FIX, then held under back-pressure
        start_op(8'h05, 8'hFA, 1'b1, 1'b1);
        wait_valid(lat);
        chk("op3_latency", lat, 3);
        chk("op3_sum", sum_o, 8'h00);
        chk("op3_cout", cout_o, 1);
        chk("op3_err", err_o, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_valid", out_valid_o, 1);
            chk("hold_ready", in_ready_o, 0);
            chk("hold_sum", sum_o, 8'h00);
            chk("hold_cout", cout_o, 1);
            chk("hold_err", err_o, 1);
        end
        handshake(1'b0);
        chk("op3_ready_after", in_ready_o, 1);
        chk("op3_valid_after", out_valid_o, 0);
        chk("op3_cnt", err_cnt_o, 2);

        // Saturation with CNT_W=4: 15 more mispredicting results
        exp_cnt = 2;
        for (int i = 0; i < 15; i++) begin
            start_op(8'h05, 8'hFA, 1'b1, 1'b0);
            wait_valid(lat);
            handshake(1'b0);
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            chk("sat_cnt", err_cnt_o, exp_cnt);
        end
        chk("sat_final", err_cnt_o, 4'hF);

        // Clear wins over a same-cycle mispredicting handshake
        start_op(8'h05, 8'hFA, 1'b1, 1'b0);
        wait_valid(lat);
        chk("clr_err", err_o, 1);
        handshake(1'b1);
        chk("clr_cnt", err_cnt_o, 0);

        start_op(8'h05, 8'hFA, 1'b1, 1'b0);
        wait_valid(lat);
        handshake(1'b0);
        chk("pre_rst_cnt", err_cnt_o, 1);

        // Reset while in FIX abandons the operation
        start_op(8'h05, 8'hFA, 1'b1, 1'b1);
        @(negedge clk_i);
        chk("fix_valid", out_valid_o, 0);
        chk("fix_ready", in_ready_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("rst_fix_valid", out_valid_o, 0);
        chk("rst_fix_cnt", err_cnt_o, 0);
        chk("rst_fix_ready", in_ready_o, 1);
        chk("rst_fix_sum", sum_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        start_op(8'h01, 8'h01, 1'b0, 1'b1);
        wait_valid(lat);
        chk("op4_latency", lat, 2);
        chk("op4_sum", sum_o, 8'h02);
        chk("op4_err", err_o, 0);
        handshake(1'b0);
        chk("op4_cnt", err_cnt_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cesa_seq_adder.md
# cesa_seq_adder

- Parametrised, handshaked carry-estimating speculative adder built from 4-bit segments.
- Each segment's carry-in is predicted by the carry estimator of the segment below, so the speculative sum has no long ripple chain.
- A registered check compares every estimated carry against the true carry. In exact mode, a mispredicted operation is corrected in one extra cycle.
- Sits in the core's arithmetic datapath as the multi-cycle successor to the single-segment estimator block, and keeps a misprediction counter for characterisation.

## Interface
Parameters:
- WIDTH, 32, operand width; multiple of 4, minimum 8; NSEG = WIDTH/4 segments.
- CNT_W, 16, width of the misprediction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  operand request valid.
- in_ready_o  out  1  block can accept operands.
- a_i, b_i  in  WIDTH  operands.
- cin_i  in  1  carry into segment 0.
- mode_i  in  1  0 = approximate (speculative result only), 1 = exact (correct on misprediction).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- sum_o  out  WIDTH  result sum.
- cout_o  out  1  result carry-out.
- err_o  out  1  a misprediction was detected for this result.
- clr_cnt_i  in  1  synchronous clear of err_cnt_o.
- err_cnt_o  out  CNT_W  saturating count of results delivered with err_o=1.

## Operation
- FSM states: IDLE, SPEC, FIX, HOLD.
- in_ready_o = (state == IDLE).
- Accept: in_valid_i && in_ready_o at a rising edge. This captures a_i, b_i, cin_i and mode_i into registers and moves the FSM IDLE -> SPEC.
- The estimator for segment k with bits x=a3, y=b3, z=a2, w=b2, p=a1, q=b1, r=a0, s=b0 (segment-local) is:
  - sel = (x^y)&(z^w)
  - pre = maj(p, q, r&s)
  - post = maj(x, y, z&w)
  - est_k = sel ? pre : post
- Speculative carry into segment 0 is the registered cin. Speculative carry into segment k>0 is est_{k-1}. Each segment ripples internally from its own carry-in. Speculative cout = est_{NSEG-1}.
- True carries come from a full ripple of all WIDTH bits from the registered cin.
- mis = OR over k = 0..NSEG-1 of (est_k != true carry-out of segment k).
- SPEC -> HOLD when mode = 0 or mis = 0:
  - sum_o/cout_o load the speculative result.
  - err_o loads mis.
- SPEC -> FIX when mode = 1 and mis = 1. FIX -> HOLD loads the exact sum/cout with err_o = 1.
- FIX must not be a single-cycle WIDTH-bit ripple. It is at most a per-segment correction using true carries registered in SPEC.
- HOLD: out_valid_o = 1. sum_o, cout_o and err_o stay stable until out_ready_i. HOLD -> IDLE on out_valid_o && out_ready_i.
- err_cnt_o increments by 1 on each output handshake with err_o = 1 and saturates at all-ones.
- clr_cnt_i has priority over the increment. If both occur in the same cycle, the counter becomes 0.
- In approximate mode the estimator mispredicts only when a segment fully propagates (sel=1 and p^q=1 and r^s=1) and its true carry-in is 1.

## Timing
- Reset (rst_ni low, asynchronous):
  - state = IDLE, so in_ready_o = 1.
  - out_valid_o = 0, sum_o = 0, cout_o = 0, err_o = 0, err_cnt_o = 0, operand registers = 0.
  - No accept occurs while rst_ni is low.
- Latency, with acceptance in cycle n:
  - SPEC in n+1.
  - out_valid_o in n+2 when no correction is needed.
  - out_valid_o in n+3 when a correction is needed.
- Throughput: one operation in flight. After the output handshake in cycle m, in_ready_o = 1 in cycle m+1.
- out_valid_o never drops without out_ready_i. Back-pressure holds HOLD indefinitely.
- Reset asserted mid-operation (SPEC, FIX or HOLD) abandons the operation. Outputs return to their reset values immediately and err_cnt_o is not incremented.
- Input changes while in_ready_o = 0 are ignored.

## Test plan
- WIDTH=8, a=0x12, b=0x34, cin=0, mode=1 -> sum_o=0x46, cout_o=0, err_o=0; out_valid_o 2 cycles after accept; err_cnt_o unchanged.
- WIDTH=8, a=0x05, b=0xFA, cin=1, mode=0 -> sum_o=0xF0, cout_o=0, err_o=1 at latency 2; err_cnt_o +1 on handshake.
- Same operands with mode=1 -> sum_o=0x00, cout_o=1, err_o=1 at latency 3 (passes through FIX).
- Hold out_ready_i=0 for 5 cycles in HOLD -> outputs stable and in_ready_o=0 throughout; release -> in_ready_o=1 the next cycle.
- Drive 0xFFFF+2 mispredicting ops (CNT_W=16) -> err_cnt_o saturates at 0xFFFF. Assert clr_cnt_i in the same cycle as a mispredicting handshake -> err_cnt_o=0.
- Assert rst_ni=0 while in FIX -> out_valid_o=0 and err_cnt_o=0 immediately. After release, accept a=0x01, b=0x01, cin=0 -> sum_o=0x02, err_o=0.
